// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and data ports share one memory port.
// Data normally wins; fetch is forced through after STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    // state     | meaning
    // IDLE      | no transaction, arbitrate and grant
    // ISSUE     | command on the memory port until accepted
    // WAIT_RESP | command accepted, waiting for the response
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data port, 0 = fetch port
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              fetch_win, data_win, resp, idle;

    assign idle      = (state_q == IDLE);
    assign fetch_win = i_if_req && (!i_d_req || (starve_q == STARVE_LIM));
    assign data_win  = i_d_req && !fetch_win;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        resp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    state_d  = ISSUE;
                    owner_d  = 1'b0;
                    addr_d   = i_if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = '1;
                    starve_d = '0;
                end else if (data_win) begin
                    state_d = ISSUE;
                    owner_d = 1'b1;
                    addr_d  = i_d_addr;
                    we_d    = i_d_we;
                    wdata_d = i_d_wdata;
                    be_d    = i_d_be;
                    if (i_if_req && (starve_q != STARVE_LIM))
                        starve_d = starve_q + 1'b1;
                end
            end
            ISSUE: begin
                if (i_mem_ready)
                    state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (i_mem_rvalid) begin
                    resp    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    // Grants are combinational from the requests, so reset must mask them too.
    assign o_if_gnt    = i_rst && idle && fetch_win;
    assign o_d_gnt     = i_rst && idle && data_win;
    assign o_if_rvalid = resp && !owner_q;
    assign o_d_rvalid  = resp && owner_q;
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
    assign o_mem_req   = (state_q == ISSUE);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;
    assign o_busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, contention,
// backpressure, spurious responses and reset during a transaction.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt, o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_d_req, i_d_we;
    logic [31:0] i_d_addr, i_d_wdata;
    logic [3:0]  i_d_be;
    logic        o_d_gnt, o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_be(i_d_be), .o_d_gnt(o_d_gnt),
        .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Inputs are driven 2 ns after the rising edge, outputs checked 1 ns later.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h0;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h0; i_d_wdata = 32'h0; i_d_be = 4'h0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        #3;
        n_checks++; if (o_if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt: got %b exp 0", o_if_gnt); end
        n_checks++; if (o_d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt: got %b exp 0", o_d_gnt); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
        n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b exp 0", o_mem_req); end
        n_checks++; if ({o_mem_addr, o_mem_be, o_mem_we} !== 37'h0) begin n_fail++; $display("FAIL reset_mem_cmd: got %h exp 0", {o_mem_addr, o_mem_be, o_mem_we}); end
        i_if_req = 1'b0; i_d_req = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        i_if_req = 1'b1; i_if_addr = 32'h10; i_mem_ready = 1'b1;
        #1;
        n_checks++; if (o_if_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt: got %b exp 1", o_if_gnt); end
        n_checks++; if (o_d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_d_gnt: got %b exp 0", o_d_gnt); end
        n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_at_n: got %b exp 0", o_mem_req); end
        tick();
        i_if_req = 1'b0; i_if_addr = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req_n1: got %b exp 1", o_mem_req); end
        n_checks++; if (o_mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_addr: got %h exp 00000010", o_mem_addr); end
        n_checks++; if ({o_mem_we, o_mem_be} !== 5'b0_1111) begin n_fail++; $display("FAIL fetch_we_be: got %b exp 01111", {o_mem_we, o_mem_be}); end
        n_checks++; if (o_if_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt_issue: got %b exp 0", o_if_gnt); end
        tick();
        i_mem_ready = 1'b0;
        #1;
        n_checks++; if ({o_mem_req, o_busy, o_if_rvalid} !== 3'b010) begin n_fail++; $display("FAIL fetch_wait: got %b exp 010", {o_mem_req, o_busy, o_if_rvalid}); end
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (o_if_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid: got %b exp 1", o_if_rvalid); end
        n_checks++; if (o_if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h exp deadbeef", o_if_rdata); end
        n_checks++; if ({o_d_rvalid, o_d_rdata} !== 33'h0) begin n_fail++; $display("FAIL fetch_d_side: got %h exp 0", {o_d_rvalid, o_d_rdata}); end
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        n_checks++; if ({o_busy, o_if_rvalid, o_if_rdata} !== 34'h0) begin n_fail++; $display("FAIL fetch_done: got %h exp 0", {o_busy, o_if_rvalid, o_if_rdata}); end
    endtask

    task automatic test_contention();
        logic [9:0] pat;
        logic       exp_f;
        pat = 10'b10_0001_0000;
        tick();
        i_if_req = 1'b1; i_if_addr = 32'h100;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h200;
        i_mem_ready = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5A5A_0000;
        for (int i = 0; i < 10; i++) begin
            exp_f = pat[i];
            i_mem_rdata = 32'h5A5A_0000 + i;
            #1;
            n_checks++; if ({o_if_gnt, o_d_gnt} !== {exp_f, ~exp_f}) begin n_fail++; $display("FAIL contention_gnt[%0d]: got if/d=%b%b exp %b%b", i, o_if_gnt, o_d_gnt, exp_f, ~exp_f); end
            tick();
            #1;
            n_checks++; if (o_mem_addr !== (exp_f ? 32'h100 : 32'h200)) begin n_fail++; $display("FAIL contention_addr[%0d]: got %h exp %h", i, o_mem_addr, exp_f ? 32'h100 : 32'h200); end
            tick();
            if (i == 9) begin i_if_req = 1'b0; i_d_req = 1'b0; end
            #1;
            n_checks++; if ({o_if_rvalid, o_d_rvalid} !== {exp_f, ~exp_f}) begin n_fail++; $display("FAIL contention_rvalid[%0d]: got if/d=%b%b exp %b%b", i, o_if_rvalid, o_d_rvalid, exp_f, ~exp_f); end
            n_checks++; if ((exp_f ? o_d_rdata : o_if_rdata) !== 32'h0) begin n_fail++; $display("FAIL contention_other_rdata[%0d]: got %h exp 0", i, exp_f ? o_d_rdata : o_if_rdata); end
            tick();
        end
        i_mem_rvalid = 1'b0; i_mem_ready = 1'b0;
        #1;
        n_checks++; if ({o_busy, o_if_gnt, o_d_gnt} !== 3'b000) begin n_fail++; $display("FAIL contention_end: got %b exp 000", {o_busy, o_if_gnt, o_d_gnt}); end
    endtask

    task automatic test_backpressure();
        tick();
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h40; i_d_wdata = 32'h12345678; i_d_be = 4'b0011;
        i_mem_ready = 1'b0;
        #1;
        n_checks++; if (o_d_gnt !== 1'b1) begin n_fail++; $display("FAIL bp_gnt: got %b exp 1", o_d_gnt); end
        tick();
        i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = 32'hAAAA_AAAA; i_d_wdata = 32'h0; i_d_be = 4'hC;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) i_mem_ready = 1'b1;
            #1;
            n_checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be} !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}) begin n_fail++; $display("FAIL bp_cmd_c%0d: got %h exp %h", c, {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be}, {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}); end
            tick();
        end
        i_mem_ready = 1'b0;
        #1;
        n_checks++; if ({o_mem_req, o_busy, o_d_rvalid} !== 3'b010) begin n_fail++; $display("FAIL bp_wait: got %b exp 010", {o_mem_req, o_busy, o_d_rvalid}); end
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
        #1;
        n_checks++; if ({o_d_rvalid, o_if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL bp_ack: got %b exp 10", {o_d_rvalid, o_if_rvalid}); end
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b exp 0", o_busy); end
    endtask

    task automatic test_spurious();
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_2222;
        #1;
        n_checks++; if ({o_if_rvalid, o_d_rvalid, o_busy} !== 3'b000) begin n_fail++; $display("FAIL spur_idle: got %b exp 000", {o_if_rvalid, o_d_rvalid, o_busy}); end
        tick();
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_state: got %b exp 0", o_busy); end
        i_mem_rvalid = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h80; i_mem_ready = 1'b0;
        tick();
        i_if_req = 1'b0; i_mem_rvalid = 1'b1;
        #1;
        n_checks++; if ({o_if_rvalid, o_d_rvalid, o_mem_req} !== 3'b001) begin n_fail++; $display("FAIL spur_issue: got %b exp 001", {o_if_rvalid, o_d_rvalid, o_mem_req}); end
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        n_checks++; if ({o_mem_req, o_busy} !== 2'b11) begin n_fail++; $display("FAIL spur_issue_state: got %b exp 11", {o_mem_req, o_busy}); end
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0080;
        #1;
        n_checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h80}) begin n_fail++; $display("FAIL spur_resp: got %h exp 100000080", {o_if_rvalid, o_if_rdata}); end
        tick();
        i_mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        i_if_req = 1'b1; i_if_addr = 32'h30; i_mem_ready = 1'b1;
        tick();
        i_if_req = 1'b0;
        tick();
        i_mem_ready = 1'b0;
        #1;
        n_checks++; if ({o_busy, o_mem_req} !== 2'b10) begin n_fail++; $display("FAIL rm_wait: got %b exp 10", {o_busy, o_mem_req}); end
        i_rst = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
        #1;
        n_checks++; if ({o_busy, o_mem_req, o_if_rvalid, o_d_rvalid, o_if_gnt, o_d_gnt} !== 6'b0) begin n_fail++; $display("FAIL rm_ctrl: got %b exp 000000", {o_busy, o_mem_req, o_if_rvalid, o_d_rvalid, o_if_gnt, o_d_gnt}); end
        n_checks++; if ({o_mem_addr, o_mem_wdata, o_mem_be, o_mem_we, o_if_rdata, o_d_rdata} !== 133'h0) begin n_fail++; $display("FAIL rm_data: got %h exp 0", {o_mem_addr, o_mem_wdata, o_mem_be, o_mem_we, o_if_rdata, o_d_rdata}); end
        tick();
        i_rst = 1'b1;
        tick();
        #1;
        n_checks++; if ({o_if_rvalid, o_d_rvalid, o_busy} !== 3'b000) begin n_fail++; $display("FAIL rm_late_rvalid: got %b exp 000", {o_if_rvalid, o_d_rvalid, o_busy}); end
        i_mem_rvalid = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h20; i_mem_ready = 1'b1;
        #1;
        n_checks++; if (o_if_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_gnt: got %b exp 1", o_if_gnt); end
        tick();
        i_if_req = 1'b0;
        #1;
        n_checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL rm_fresh_cmd: got %h exp 100000020", {o_mem_req, o_mem_addr}); end
        tick();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        #1;
        n_checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("FAIL rm_fresh_resp: got %h exp 1cafef00d", {o_if_rvalid, o_if_rdata}); end
        tick();
        i_mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting.
REQ-002 Reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch read request
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_if_rvalid  out  1  fetch data valid (1-cycle pulse)
- o_if_rdata  out  DATA_W  fetch read data
- i_d_req  in  1  data request
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- i_d_be  in  DATA_W/8  store byte enables
- o_d_gnt  out  1  data request accepted (1-cycle pulse)
- o_d_rvalid  out  1  load data / store ack (1-cycle pulse)
- o_d_rdata  out  DATA_W  load data
- o_mem_req, o_mem_we  out  1 each  memory request, write enable
- o_mem_addr, o_mem_wdata, o_mem_be  out  ADDR_W, DATA_W, DATA_W/8  memory command fields
- i_mem_ready  in  1  memory accepts the command when high with o_mem_req
- i_mem_rvalid  in  1  memory response (read data or write ack)
- i_mem_rdata  in  DATA_W  memory read data
- o_busy  out  1  a transaction is in flight (state != IDLE)

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT_RESP; at most one transaction SHALL be outstanding.
REQ-005 In IDLE with any request asserted, the arbiter SHALL select a winner, pulse the winner's gnt for that cycle, latch the winner's command fields and owner ID, and go to ISSUE.
REQ-006 Priority SHALL be data over fetch, except that fetch SHALL win when i_if_req=1 and starve_cnt==STARVE_MAX.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_MAX) on each data grant while i_if_req=1, SHALL clear on each fetch grant, and SHALL hold otherwise.
REQ-008 Fetch commands SHALL be issued with o_mem_we=0 and o_mem_be all-ones.
REQ-009 In ISSUE, o_mem_req SHALL be 1 with the latched fields held stable; on i_mem_ready=1 the FSM SHALL go to WAIT_RESP, otherwise it SHALL stay in ISSUE indefinitely.
REQ-010 In WAIT_RESP, o_mem_req SHALL be 0; on i_mem_rvalid=1 the arbiter SHALL pulse the owner's rvalid in the same cycle, drive that owner's rdata from i_mem_rdata combinationally, and go to IDLE.
REQ-011 Latency SHALL be: gnt in cycle N, o_mem_req from N+1, rvalid in the cycle i_mem_rvalid arrives, and the earliest next grant in the following cycle (one IDLE cycle between transactions).
REQ-012 i_mem_rvalid in IDLE or ISSUE SHALL be ignored, with no rvalid pulse and no state change.
REQ-013 Requesters' inputs SHALL be ignored outside IDLE; gnt SHALL be 0 outside IDLE, and a requester SHALL hold its request until it is granted.
REQ-014 A non-owner's rvalid SHALL never assert, and both gnt signals SHALL never assert in the same cycle.
REQ-015 o_if_rdata and o_d_rdata SHALL be 0 whenever the corresponding rvalid is 0.

Reset
REQ-016 On reset assertion, the arbiter SHALL immediately, regardless of clock, enter IDLE, clear starve_cnt, the owner ID and the latched command, and drive every output to 0.
REQ-017 After a reset taken mid-transaction, a late i_mem_rvalid SHALL be ignored per REQ-012.
REQ-018 Operation SHALL resume on the first rising edge after reset deassertion.

Verification
REQ-019 Fetch-only: i_if_req=1, addr=0x10, memory ready at once with rvalid 2 cycles later and rdata=0xDEADBEEF -> o_if_gnt at N, o_mem_req at N+1, o_if_rvalid with rdata 0xDEADBEEF, o_d_rvalid stays 0.
REQ-020 Contention: i_if_req and i_d_req both held high -> grant order D,D,D,D,I,D,D,D,D,I, with starve_cnt returning to 0 after each fetch grant.
REQ-021 Backpressure: i_mem_ready=0 for 5 cycles during a store (addr=0x40, wdata=0x12345678, be=4'b0011) -> o_mem_req and all command fields stable for 5 cycles, accepted on cycle 6, o_d_rvalid on ack.
REQ-022 Spurious response: i_mem_rvalid pulsed while in IDLE and while in ISSUE -> no rvalid output and no state change.
REQ-023 Reset in WAIT_RESP: i_rst=0 asynchronously -> o_busy=0 and all outputs 0 immediately; a subsequent i_mem_rvalid produces no pulse; a fresh fetch completes normally.
